// File: rtl/tick_scheduler_if.sv
// ---------------------------------------------------------------------------
// tick_scheduler_if
//   Configuration bus between the paint control FSM (master) and the shared
//   tick scheduler (slave). A write is taken on any clock where the master
//   holds cfg_we high and the slave reports cfg_ready; a write offered while
//   cfg_ready is low is simply not taken, so the master keeps it asserted.
//
// Signals
//   cfg_we      master -> slave  config write strobe
//   cfg_ch      master -> slave  channel to configure            [IDX_W]
//   cfg_period  master -> slave  period in base ticks, 0 = never  [CNT_W]
//   cfg_en      master -> slave  channel enable
//   cfg_ready   slave -> master  1 = a write is accepted this clock
// ---------------------------------------------------------------------------
interface tick_scheduler_if #(
  parameter int IDX_W = 2,
  parameter int CNT_W = 28
) ();

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic             cfg_en;
  logic             cfg_ready;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_period,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_period,
    input  cfg_en,
    output cfg_ready
  );

endinterface

// File: rtl/tick_scheduler.sv
// ---------------------------------------------------------------------------
// tick_scheduler
//   Shares one prescaler and one down-count datapath among NUM_CH periodic
//   timers (brush repeat, cursor blink, animation step, ...).
//
//   A free-running prescaler produces one base tick every BASE_DIV clocks.
//   Each base tick starts a sweep that visits the channels one per clock,
//   channel 0 first. An enabled channel with a non-zero period whose count
//   is exhausted produces a one-clock pulse on its tick bit, one clock after
//   it is visited, and reloads; otherwise its count steps down by one.
//   A channel of period P therefore ticks once every P base ticks, and the
//   first tick after a config write arrives P base ticks later.
//
//   The config port only accepts writes between sweeps, so the sweep never
//   has to arbitrate the count registers against the config port.
//
// Parameters
//   NUM_CH    number of timer channels
//   IDX_W     channel index width, clog2(NUM_CH)
//   CNT_W     period / count width
//   BASE_DIV  clocks per base tick, must be >= 2
//
// Ports
//   clock     in   system clock, all logic on the rising edge
//   resetN    in   synchronous, active-low reset
//   cfg       slave side of tick_scheduler_if (write strobe, channel,
//             period, enable in; cfg_ready out, high while idle)
//   tick      out  one-clock expiry pulse per channel, registered
//   busy      out  high while a sweep is in progress
//   overrun   out  sticky, set when a base tick lands during a sweep
//                  (only possible when BASE_DIV < NUM_CH + 1)
// ---------------------------------------------------------------------------
module tick_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 28,
  parameter int BASE_DIV = 50000
) (
  input  logic              clock,
  input  logic              resetN,
  tick_scheduler_if.slave   cfg,
  output logic [NUM_CH-1:0] tick,
  output logic              busy,
  output logic              overrun
);

  localparam int               PRE_W      = $clog2(BASE_DIV);
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(BASE_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  logic [PRE_W-1:0] prescaler;
  logic             base_tick;

  logic             ready;
  logic             cfg_accept;

  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [NUM_CH-1:0] en_q;

  logic             ch_active;
  logic             ch_expire;
  logic [CNT_W-1:0] cfg_count;

  // Prescaler runs regardless of the FSM so the base tick rate stays exact
  // even when a tick has to be dropped.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      prescaler <= PRE_RELOAD;
    end else if (base_tick) begin
      prescaler <= PRE_RELOAD;
    end else begin
      prescaler <= prescaler - PRE_W'(1);
    end
  end

  assign base_tick = (prescaler == '0);

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // A base tick seen in SWEEP is not remembered: the sweep finishes normally
  // and that base tick is lost (flagged on overrun).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (base_tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign cfg.cfg_ready = ready;
  assign cfg_accept    = cfg.cfg_we & ready;

  // A period of 0 leaves the count at 0 instead of wrapping to all ones;
  // such a channel is never processed anyway.
  assign cfg_count = (cfg.cfg_period == '0) ? '0 : cfg.cfg_period - CNT_W'(1);

  assign ch_active = busy & en_q[idx_q] & (period_q[idx_q] != '0);
  assign ch_expire = ch_active & (count_q[idx_q] == '0);

  // Config writes and sweep updates never coincide because writes are only
  // accepted in IDLE. A write on the same clock as a base tick therefore
  // lands before the sweep that starts on the next clock.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
      en_q <= '0;
    end else if (cfg_accept) begin
      period_q[cfg.cfg_ch] <= cfg.cfg_period;
      en_q[cfg.cfg_ch]     <= cfg.cfg_en;
      count_q[cfg.cfg_ch]  <= cfg_count;
    end else if (ch_active) begin
      if (ch_expire) begin
        count_q[idx_q] <= period_q[idx_q] - CNT_W'(1);
      end else begin
        count_q[idx_q] <= count_q[idx_q] - CNT_W'(1);
      end
    end
  end

  // Only one channel is visited per clock, so at most one bit is ever set.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      tick <= '0;
    end else begin
      tick <= '0;
      if (ch_expire) begin
        tick[idx_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      overrun <= 1'b0;
    end else if (base_tick && (state_q == SWEEP)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tick_scheduler
//   Self-checking bench for tick_scheduler. The main instance runs with
//   BASE_DIV=8 and is compared every cycle against a behavioural model that
//   counts cycles since reset and keeps, per channel, the number of base
//   ticks left until its next expiry. A second instance with BASE_DIV=3
//   exercises the overrun flag. Directed checks with hand-computed literals
//   pin the model at specific cycles.
// ---------------------------------------------------------------------------
module tb_tick_scheduler;

  localparam int NUM_CH   = 4;
  localparam int IDX_W    = 2;
  localparam int CNT_W    = 28;
  localparam int BASE_DIV = 8;
  localparam int OVR_DIV  = 3;

  logic              clock = 1'b0;
  logic              resetN;
  logic              resetN_ovr;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] tick_ovr;
  logic              busy;
  logic              busy_ovr;
  logic              overrun;
  logic              overrun_ovr;

  tick_scheduler_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) cfg_if ();
  tick_scheduler_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) cfg_if_ovr ();

  tick_scheduler #(
    .NUM_CH(NUM_CH), .IDX_W(IDX_W), .CNT_W(CNT_W), .BASE_DIV(BASE_DIV)
  ) dut (
    .clock(clock), .resetN(resetN), .cfg(cfg_if.slave),
    .tick(tick), .busy(busy), .overrun(overrun)
  );

  tick_scheduler #(
    .NUM_CH(NUM_CH), .IDX_W(IDX_W), .CNT_W(CNT_W), .BASE_DIV(OVR_DIV)
  ) dut_ovr (
    .clock(clock), .resetN(resetN_ovr), .cfg(cfg_if_ovr.slave),
    .tick(tick_ovr), .busy(busy_ovr), .overrun(overrun_ovr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cyc is the index of the current cycle counted from the
  // first cycle after the last reset edge.
  int          cyc         = 0;
  bit          model_valid = 1'b0;
  int unsigned m_period [NUM_CH];
  bit          m_en     [NUM_CH];
  int unsigned m_left   [NUM_CH];
  int          m_pend   [NUM_CH];
  logic [NUM_CH-1:0] exp_tick;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  function automatic bit modelBusy(input int c);
    return (c >= BASE_DIV) && ((c % BASE_DIV) < NUM_CH);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_period[k] = 0;
      m_en[k]     = 1'b0;
      m_left[k]   = 0;
      m_pend[k]   = -1;
    end
    cyc = 0;
  endtask

  // Compare, then advance the model by the events of this cycle.
  always @(negedge clock) begin
    if (model_valid) begin
      exp_tick = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (m_pend[k] == cyc) exp_tick[k] = 1'b1;
      end
      checkOutput("tick", 32'(tick), 32'(exp_tick));
      checkOutput("busy", 32'(busy), 32'(modelBusy(cyc)));
      checkOutput("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!modelBusy(cyc)));
      checkOutput("overrun", 32'(overrun), 32'd0);
    end
    if (resetN !== 1'b1) begin
      modelReset();
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (cfg_if.cfg_we === 1'b1 && !modelBusy(cyc)) begin
        m_period[int'(cfg_if.cfg_ch)] = int'(cfg_if.cfg_period);
        m_en[int'(cfg_if.cfg_ch)]     = cfg_if.cfg_en;
        m_left[int'(cfg_if.cfg_ch)]   = int'(cfg_if.cfg_period);
      end
      if ((cyc % BASE_DIV) == BASE_DIV - 1) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (m_en[k] && m_period[k] != 0) begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
              m_pend[k] = cyc + 2 + k;
              m_left[k] = m_period[k];
            end
          end
        end
      end
      cyc++;
    end
  end

  // Drive a config write and hold it until the DUT reports ready.
  task automatic applyStimulus(input int ch, input int unsigned period, input bit en);
    int guard = 0;
    @(posedge clock);
    #1;
    cfg_if.cfg_we     = 1'b1;
    cfg_if.cfg_ch     = IDX_W'(ch);
    cfg_if.cfg_period = CNT_W'(period);
    cfg_if.cfg_en     = en;
    @(negedge clock);
    while (cfg_if.cfg_ready !== 1'b1 && guard < 20) begin
      guard++;
      @(negedge clock);
    end
    if (guard >= 20) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL cfg_write_timeout: ready never seen for ch %0d", ch);
    end
    @(posedge clock);
    #1;
    cfg_if.cfg_we = 1'b0;
  endtask

  // Advance to the given cycle; checks afterwards happen at posedge+2.
  task automatic waitCycle(input int target);
    int guard = 0;
    do begin
      @(posedge clock);
      #2;
      guard++;
    end while (cyc != target && guard < 400);
    if (cyc != target) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_cycle: reached %0d, wanted %0d", cyc, target);
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN                = 1'b0;
    resetN_ovr            = 1'b0;
    cfg_if.cfg_we         = 1'b0;
    cfg_if.cfg_ch         = '0;
    cfg_if.cfg_period     = '0;
    cfg_if.cfg_en         = 1'b0;
    cfg_if_ovr.cfg_we     = 1'b0;
    cfg_if_ovr.cfg_ch     = '0;
    cfg_if_ovr.cfg_period = '0;
    cfg_if_ovr.cfg_en     = 1'b0;

    $display("[TB] reset for two clocks");
    repeat (2) @(posedge clock);
    #1;
    resetN     = 1'b1;
    resetN_ovr = 1'b1;
    #1;
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    checkOutput("ovr_rst_busy", 32'(busy_ovr), 32'd0);

    $display("[TB] overrun instance, BASE_DIV=3");
    waitCycle(3);
    checkOutput("ovr_busy_c3", 32'(busy_ovr), 32'd1);
    waitCycle(5);
    checkOutput("ovr_overrun_c5", 32'(overrun_ovr), 32'd0);
    waitCycle(6);
    checkOutput("ovr_overrun_c6", 32'(overrun_ovr), 32'd1);
    checkOutput("ovr_busy_c6", 32'(busy_ovr), 32'd1);
    waitCycle(7);
    checkOutput("ovr_busy_c7", 32'(busy_ovr), 32'd0);
    waitCycle(8);
    checkOutput("busy_c8", 32'(busy), 32'd1);
    waitCycle(9);
    checkOutput("ovr_busy_c9", 32'(busy_ovr), 32'd1);
    waitCycle(11);
    checkOutput("busy_c11", 32'(busy), 32'd1);
    waitCycle(12);
    checkOutput("busy_c12", 32'(busy), 32'd0);
    checkOutput("ready_c12", 32'(cfg_if.cfg_ready), 32'd1);

    $display("[TB] ch0 period 1");
    applyStimulus(0, 1, 1'b1);
    waitCycle(16);
    checkOutput("ch0_c16", 32'(tick), 32'h0);
    waitCycle(17);
    checkOutput("ch0_c17", 32'(tick), 32'h1);
    waitCycle(18);
    checkOutput("ch0_c18", 32'(tick), 32'h0);
    waitCycle(25);
    checkOutput("ch0_c25", 32'(tick), 32'h1);

    $display("[TB] ch1 period 3, offered during a sweep");
    applyStimulus(1, 3, 1'b1);
    waitCycle(49);
    checkOutput("ch1_c49", 32'(tick), 32'h1);
    waitCycle(50);
    checkOutput("ch1_c50", 32'(tick), 32'h2);
    waitCycle(74);
    checkOutput("ch1_c74", 32'(tick), 32'h2);

    $display("[TB] ch2 period 2, disable, re-enable");
    applyStimulus(2, 2, 1'b1);
    waitCycle(91);
    checkOutput("ch2_c91", 32'(tick), 32'h4);
    applyStimulus(2, 2, 1'b0);
    waitCycle(107);
    checkOutput("ch2_off_c107", 32'(tick), 32'h0);
    applyStimulus(2, 2, 1'b1);
    waitCycle(122);
    checkOutput("ch1_c122", 32'(tick), 32'h2);
    waitCycle(123);
    checkOutput("ch2_on_c123", 32'(tick), 32'h4);

    $display("[TB] write coincident with base tick, write held over sweep");
    waitCycle(126);
    applyStimulus(3, 1, 1'b1);
    waitCycle(132);
    checkOutput("ch3_coinc_c132", 32'(tick), 32'h8);
    waitCycle(136);
    checkOutput("ready_c136", 32'(cfg_if.cfg_ready), 32'd0);
    checkOutput("busy_c136", 32'(busy), 32'd1);
    applyStimulus(3, 2, 1'b1);
    waitCycle(148);
    checkOutput("ch3_held_c148", 32'(tick), 32'h0);
    waitCycle(156);
    checkOutput("ch3_held_c156", 32'(tick), 32'h8);

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(2, 1, 1'b1);
    waitCycle(161);
    @(posedge clock);
    #1;
    resetN = 1'b0;
    @(posedge clock);
    #1;
    resetN = 1'b1;
    #1;
    checkOutput("midrst_tick", 32'(tick), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    waitCycle(9);
    checkOutput("cleared_c9", 32'(tick), 32'h0);
    waitCycle(17);
    checkOutput("cleared_c17", 32'(tick), 32'h0);
    checkOutput("ovr_sticky", 32'(overrun_ovr), 32'd1);
    checkOutput("main_no_overrun", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
